// File: rtl/mips_cpu_memaccess.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mips_cpu_memaccess
// Function : Load/store unit bridging the CPU datapath to an Avalon-MM data
//            bus. Loads return the raw bus word plus byte offset; stores get
//            lane-replicated data and byte enables.
// Option   : define MIPS_MEMACCESS_TIMEOUT_EN to abort bus transactions that
//            stall on waitrequest for TIMEOUT_CYCLES consecutive cycles.
// Revision : 1.0 - initial release
// ============================================================================
module mips_cpu_memaccess #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic [5:0]  opcode,
   input  logic [31:0] addr,
   input  logic [31:0] storedata,
   output logic        busy,
   output logic        done,
   output logic        load_valid,
   output logic [31:0] load_data,
   output logic [1:0]  vaddr,
   output logic        addr_err,
   output logic        timeout_err,
   output logic [31:0] avm_address,
   output logic        avm_read,
   output logic        avm_write,
   output logic [31:0] avm_writedata,
   output logic [3:0]  avm_byteenable,
   input  logic [31:0] avm_readdata,
   input  logic        avm_waitrequest
);

   localparam logic [5:0] c_OP_LB  = 6'b100000;
   localparam logic [5:0] c_OP_LH  = 6'b100001;
   localparam logic [5:0] c_OP_LWL = 6'b100010;
   localparam logic [5:0] c_OP_LW  = 6'b100011;
   localparam logic [5:0] c_OP_LBU = 6'b100100;
   localparam logic [5:0] c_OP_LHU = 6'b100101;
   localparam logic [5:0] c_OP_LWR = 6'b100110;
   localparam logic [5:0] c_OP_SB  = 6'b101000;
   localparam logic [5:0] c_OP_SH  = 6'b101001;
   localparam logic [5:0] c_OP_SW  = 6'b101011;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_WRITE = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;

   logic [5:0]  r_opcode;
   logic [31:0] r_addr;
   logic [31:0] r_storedata;
   logic        r_is_load;
   logic        r_err;
   logic [31:0] r_load_data;
   logic [1:0]  r_vaddr;

   logic        w_in_load;
   logic        w_in_store;
   logic        w_in_misal;
   logic        w_in_err;
   logic        w_accept;
   logic        w_capture;
   logic        w_tmo_hit;
   logic        w_tout;

   // Classify the incoming request: load, store, and alignment violation
   always_comb begin
      w_in_load  = 1'b0;
      w_in_store = 1'b0;
      w_in_misal = 1'b0;
      case (opcode)
         c_OP_LB, c_OP_LBU, c_OP_LWL, c_OP_LWR: w_in_load = 1'b1;
         c_OP_LH, c_OP_LHU: begin
            w_in_load  = 1'b1;
            w_in_misal = addr[0];
         end
         c_OP_LW: begin
            w_in_load  = 1'b1;
            w_in_misal = |addr[1:0];
         end
         c_OP_SB: w_in_store = 1'b1;
         c_OP_SH: begin
            w_in_store = 1'b1;
            w_in_misal = addr[0];
         end
         c_OP_SW: begin
            w_in_store = 1'b1;
            w_in_misal = |addr[1:0];
         end
         default: ;
      endcase
      w_in_err = ~(w_in_load | w_in_store) | w_in_misal;
   end

`ifdef MIPS_MEMACCESS_TIMEOUT_EN
   // Counter only has to reach TIMEOUT_CYCLES-1; the hit cycle is the last stall
   localparam int c_CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);

   logic [c_CNT_W-1:0] r_cnt;
   logic               r_tout;

   assign w_tmo_hit = avm_waitrequest && (r_cnt == c_CNT_W'(TIMEOUT_CYCLES - 1));
   assign w_tout    = r_tout;

   // Stall counter: cleared on acceptance, counts waitrequest cycles on the bus
   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt  <= '0;
         r_tout <= 1'b0;
      end else if (w_accept) begin
         r_cnt  <= '0;
         r_tout <= 1'b0;
      end else if (busy && avm_waitrequest) begin
         if (w_tmo_hit)
            r_tout <= 1'b1;
         else
            r_cnt  <= r_cnt + 1'b1;
      end
   end
`else
   logic w_unused_tmo;

   assign w_tmo_hit    = 1'b0;
   assign w_tout       = 1'b0;
   assign w_unused_tmo = (TIMEOUT_CYCLES != 0);
`endif

   // State register
   always_ff @(posedge clk) begin
      if (reset)
         r_state <= S_IDLE;
      else
         r_state <= w_state_nxt;
   end

   // Next-state logic and bus/handshake strobes
   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_capture   = 1'b0;
      busy        = 1'b0;
      done        = 1'b0;
      avm_read    = 1'b0;
      avm_write   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (req) begin
               w_accept = 1'b1;
               if (w_in_err)
                  w_state_nxt = S_DONE;
               else if (w_in_load)
                  w_state_nxt = S_READ;
               else
                  w_state_nxt = S_WRITE;
            end
         end
         S_READ: begin
            busy     = 1'b1;
            avm_read = 1'b1;
            if (!avm_waitrequest) begin
               w_capture   = 1'b1;
               w_state_nxt = S_DONE;
            end else if (w_tmo_hit) begin
               w_state_nxt = S_DONE;
            end
         end
         S_WRITE: begin
            busy      = 1'b1;
            avm_write = 1'b1;
            if (!avm_waitrequest || w_tmo_hit)
               w_state_nxt = S_DONE;
         end
         S_DONE: begin
            done        = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Request latch on acceptance; load result latch on a completed read
   always_ff @(posedge clk) begin
      if (reset) begin
         r_opcode    <= '0;
         r_addr      <= '0;
         r_storedata <= '0;
         r_is_load   <= 1'b0;
         r_err       <= 1'b0;
         r_load_data <= '0;
         r_vaddr     <= '0;
      end else begin
         if (w_accept) begin
            r_opcode    <= opcode;
            r_addr      <= addr;
            r_storedata <= storedata;
            r_is_load   <= w_in_load;
            r_err       <= w_in_err;
         end
         if (w_capture) begin
            r_load_data <= avm_readdata;
            r_vaddr     <= r_addr[1:0];
         end
      end
   end

   // Lane steering: stores replicate data across lanes, loads fetch the full word
   always_comb begin
      avm_writedata  = '0;
      avm_byteenable = '0;
      if (r_state == S_READ) begin
         avm_byteenable = 4'b1111;
      end else if (r_state == S_WRITE) begin
         case (r_opcode)
            c_OP_SB: begin
               avm_writedata  = {4{r_storedata[7:0]}};
               avm_byteenable = 4'b0001 << r_addr[1:0];
            end
            c_OP_SH: begin
               avm_writedata  = {2{r_storedata[15:0]}};
               avm_byteenable = r_addr[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
               avm_writedata  = r_storedata;
               avm_byteenable = 4'b1111;
            end
         endcase
      end
   end

   assign avm_address = {r_addr[31:2], 2'b00};
   assign load_data   = r_load_data;
   assign vaddr       = r_vaddr;
   assign addr_err    = done & r_err;
   assign timeout_err = done & w_tout;
   assign load_valid  = done & r_is_load & ~r_err & ~w_tout;

endmodule
`default_nettype wire

// File: tb/tb_mips_cpu_memaccess.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_mips_cpu_memaccess
// Function : Self-checking bench for mips_cpu_memaccess: directed scenarios
//            followed by randomized ops against a behavioural model.
// Option   : MIPS_MEMACCESS_TIMEOUT_EN enables the bus-timeout scenario.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mips_cpu_memaccess;

   localparam int TMO = 4;
`ifdef MIPS_MEMACCESS_TIMEOUT_EN
   localparam bit TMO_EN = 1'b1;
`else
   localparam bit TMO_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        req;
   logic [5:0]  opcode;
   logic [31:0] addr;
   logic [31:0] storedata;
   logic        busy;
   logic        done;
   logic        load_valid;
   logic [31:0] load_data;
   logic [1:0]  vaddr;
   logic        addr_err;
   logic        timeout_err;
   logic [31:0] avm_address;
   logic        avm_read;
   logic        avm_write;
   logic [31:0] avm_writedata;
   logic [3:0]  avm_byteenable;
   logic [31:0] avm_readdata;
   logic        avm_waitrequest;

   int          checks   = 0;
   int          failures = 0;
   logic [31:0] m_load_data;
   logic [1:0]  m_vaddr;

   mips_cpu_memaccess #(.TIMEOUT_CYCLES(TMO)) dut (
      .clk             (clk),
      .reset           (reset),
      .req             (req),
      .opcode          (opcode),
      .addr            (addr),
      .storedata       (storedata),
      .busy            (busy),
      .done            (done),
      .load_valid      (load_valid),
      .load_data       (load_data),
      .vaddr           (vaddr),
      .addr_err        (addr_err),
      .timeout_err     (timeout_err),
      .avm_address     (avm_address),
      .avm_read        (avm_read),
      .avm_write       (avm_write),
      .avm_writedata   (avm_writedata),
      .avm_byteenable  (avm_byteenable),
      .avm_readdata    (avm_readdata),
      .avm_waitrequest (avm_waitrequest)
   );

   always #5 clk = ~clk;

   // Access size in bytes for the alignment rule (lwl/lwr count as byte
   // accesses since they never trap); 0 marks a non-memory opcode.
   function automatic int op_size(input logic [5:0] op);
      case (op)
         6'b100000, 6'b100100, 6'b100010, 6'b100110, 6'b101000: return 1;
         6'b100001, 6'b100101, 6'b101001:                       return 2;
         6'b100011, 6'b101011:                                  return 4;
         default:                                               return 0;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Issue one request, play the Avalon slave, and compare against the model
   task automatic run_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] sd,
                         input int nwait, input logic [31:0] rdata);
      int          sz;
      int          lo;
      bit          is_ld;
      bit          err;
      bit          tmo;
      int          exp_edges;
      int          exp_bus;
      int          edges;
      int          bus;
      int          waits;
      logic [31:0] exp_adr;
      logic [31:0] exp_wd;
      logic [3:0]  exp_be;

      sz    = op_size(op);
      lo    = int'(a[1:0]);
      is_ld = (sz != 0) && (op[5:3] == 3'b100);
      err   = (sz == 0) ? 1'b1 : ((lo % sz) != 0);
      tmo   = TMO_EN && !err && (nwait >= TMO);

      exp_adr = a - (a % 4);
      exp_be  = 4'b1111;
      exp_wd  = sd;
      if (!is_ld && sz == 1) begin
         exp_be = 4'(1 << lo);
         exp_wd = 32'(sd[7:0]) * 32'h01010101;
      end else if (!is_ld && sz == 2) begin
         exp_be = (lo >= 2) ? 4'b1100 : 4'b0011;
         exp_wd = 32'(sd[15:0]) * 32'h00010001;
      end

      exp_edges = err ? 1 : (tmo ? 1 + TMO : 2 + nwait);
      exp_bus   = err ? 0 : (tmo ? TMO : nwait + 1);

      req             = 1'b1;
      opcode          = op;
      addr            = a;
      storedata       = sd;
      avm_waitrequest = 1'b1;
      @(posedge clk); #1;
      // Scramble the request inputs: the unit must work from its latched copy
      req       = 1'b0;
      opcode    = 6'($urandom);
      addr      = $urandom;
      storedata = $urandom;

      edges = 1;
      bus   = 0;
      waits = nwait;
      while (!done && edges < 60) begin
         if (avm_read || avm_write) begin
            bus++;
            chk("busy_on_bus", busy, 1);
            chk("avm_read", avm_read, is_ld);
            chk("avm_write", avm_write, !is_ld);
            chk("avm_address", avm_address, exp_adr);
            chk("avm_byteenable", avm_byteenable, exp_be);
            if (!is_ld)
               chk("avm_writedata", avm_writedata, exp_wd);
         end
         if (waits > 0) begin
            avm_waitrequest = 1'b1;
            avm_readdata    = $urandom;
            waits--;
         end else begin
            avm_waitrequest = 1'b0;
            avm_readdata    = rdata;
         end
         @(posedge clk); #1;
         edges++;
      end

      if (is_ld && !err && !tmo) begin
         m_load_data = rdata;
         m_vaddr     = a[1:0];
      end

      chk("done", done, 1);
      chk("latency_edges", edges, exp_edges);
      chk("bus_cycles", bus, exp_bus);
      chk("strobes_at_done", {avm_read, avm_write}, 0);
      chk("busy_at_done", busy, 0);
      chk("load_valid", load_valid, is_ld && !err && !tmo);
      chk("addr_err", addr_err, err);
      chk("timeout_err", timeout_err, tmo);
      chk("load_data", load_data, m_load_data);
      chk("vaddr", vaddr, m_vaddr);

      avm_waitrequest = 1'b0;
      avm_readdata    = $urandom;
      @(posedge clk); #1;
      chk("done_one_cycle", done, 0);
      chk("strobes_idle", {avm_read, avm_write}, 0);
      chk("load_data_hold", load_data, m_load_data);
   endtask

   // Global time bound so the run always terminates
   initial begin
      #300000;
      $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   logic [5:0] ops [10] = '{6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100,
                            6'b100101, 6'b100110, 6'b101000, 6'b101001, 6'b101011};

   // Directed scenarios, then randomized traffic
   initial begin
      logic [5:0]  rop;
      logic [31:0] ra;

      reset           = 1'b1;
      req             = 1'b0;
      opcode          = '0;
      addr            = '0;
      storedata       = '0;
      avm_readdata    = '0;
      avm_waitrequest = 1'b0;
      m_load_data     = '0;
      m_vaddr         = '0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("reset_outputs", 32'(|{busy, done, load_valid, load_data, vaddr, addr_err, timeout_err,
                                  avm_address, avm_read, avm_write, avm_writedata, avm_byteenable}), 0);
      reset = 1'b0;
      @(posedge clk); #1;
      chk("idle_done", done, 0);

      run_op(6'b100011, 32'h0000_1004, 32'h0, 2, 32'hDEAD_BEEF);  // lw, 2 waits
      run_op(6'b101000, 32'h0000_0103, 32'h0000_00A5, 0, 32'h0);  // sb lane 3
      run_op(6'b101001, 32'h0000_0202, 32'h1234_ABCD, 1, 32'h0);  // sh upper half
      run_op(6'b101001, 32'h0000_0201, 32'h1234_ABCD, 0, 32'h0);  // sh misaligned
      run_op(6'b100110, 32'h0000_0007, 32'h0, 0, 32'hCAFE_F00D);  // lwr, offset 3
      run_op(6'b000000, 32'h0000_0000, 32'h0, 0, 32'h0);          // non-memory

      // Reset while a read is stalled on waitrequest
      req             = 1'b1;
      opcode          = 6'b100011;
      addr            = 32'h0000_0040;
      avm_waitrequest = 1'b1;
      @(posedge clk); #1;
      req = 1'b0;
      @(posedge clk); #1;
      chk("stalled_read", avm_read, 1);
      reset = 1'b1;
      @(posedge clk); #1;
      chk("reset_midop_read", avm_read, 0);
      chk("reset_midop_busy", busy, 0);
      chk("reset_midop_done", done, 0);
      chk("reset_midop_all", 32'(|{busy, done, load_valid, load_data, vaddr, addr_err, timeout_err,
                                     avm_address, avm_read, avm_write, avm_writedata, avm_byteenable}), 0);
      m_load_data = '0;
      m_vaddr     = '0;
      reset       = 1'b0;
      run_op(6'b100001, 32'h0000_0012, 32'h0, 0, 32'h5566_7788);  // lh accepted right after

      if (TMO_EN)
         run_op(6'b100011, 32'h0000_2000, 32'h0, 10, 32'h1111_2222);  // timeout

      for (int i = 0; i < 40; i++) begin
         rop = ops[$urandom_range(0, 9)];
         if ($urandom_range(0, 7) == 0)
            rop = 6'($urandom);
         ra = $urandom;
         run_op(rop, ra, $urandom, int'($urandom_range(0, 3)), $urandom);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
